// File: rtl/ysyx_22040632_intr_ctrl.sv
// Machine-timer interrupt controller.
// Watches the CLINT timer request and the mstatus.MIE / mie.MTIE enables. It
// waits for an EX instruction that can be killed cleanly, then takes the
// interrupt. The take lasts one cycle and does the following:
//   - flushes IF, ID and EX;
//   - redirects fetch to the trap handler;
//   - tells the CSR file to save mepc and mcause;
//   - acknowledges the CLINT.
// After the take it waits for the request level to drop, so that one timer
// assertion produces exactly one take.
module ysyx_22040632_intr_ctrl #(
  parameter int XLEN     = 64,
  parameter int MTI_CODE = 7
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            intrrupt_timing2ex,
  input  logic            mstatus_mie_bit,
  input  logic            mie_mtie_bit,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_sys_busy,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] mtvec,
  output logic            intrrupt_ack2clint,
  output logic            trap_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_trap_wen,
  output logic [XLEN-1:0] csr_mepc_wdata,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic [31:0]     intr_taken_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TAKE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state_reg;
  logic            take_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic [31:0]     cnt_reg;

  logic            eligible;
  logic            slot;
  logic            take_now;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] handler_pc;

  assign eligible = intrrupt_timing2ex & mstatus_mie_bit & mie_mtie_bit;
  // A slot needs a real instruction that is neither stalled nor a system op.
  // A system op is allowed to finish before the interrupt is taken.
  assign slot     = ex_valid & ~ex_stall & ~ex_sys_busy;
  assign take_now = eligible & slot &
                    ((state_reg == ST_IDLE) | (state_reg == ST_WAIT));

  // Vectored mode (mode 1) adds 4*cause. Reserved modes 2 and 3 fall back to
  // direct mode. The sum wraps naturally at XLEN bits.
  assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};
  assign handler_pc = (mtvec[1:0] == 2'b01) ?
                      (mtvec_base + XLEN'(4 * MTI_CODE)) : mtvec_base;

  // Interrupt FSM. take_reg is the registered strobe for the TAKE cycle.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg <= ST_IDLE;
      take_reg  <= 1'b0;
    end else begin
      take_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (eligible && slot) begin
            state_reg <= ST_TAKE;
            take_reg  <= 1'b1;
          end else if (eligible) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (eligible && slot) begin
            state_reg <= ST_TAKE;
            take_reg  <= 1'b1;
          end else if (!eligible) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_TAKE: begin
          state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!intrrupt_timing2ex) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture the victim PC and the handler address on the same edge that
  // commits to TAKE. Both values are then held until the next take.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      mepc_reg        <= '0;
      redirect_pc_reg <= '0;
    end else if (take_now) begin
      mepc_reg        <= ex_pc;
      redirect_pc_reg <= handler_pc;
    end
  end

  // Count the interrupts taken. The counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_reg <= '0;
    end else if ((state_reg == ST_TAKE) && (cnt_reg != 32'hFFFF_FFFF)) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign intrrupt_ack2clint = take_reg;
  assign trap_flush         = take_reg;
  assign redirect_valid     = take_reg;
  assign csr_trap_wen       = take_reg;
  assign redirect_pc        = redirect_pc_reg;
  assign csr_mepc_wdata     = mepc_reg;
  assign csr_mcause_wdata   = {1'b1, (XLEN-1)'(MTI_CODE)};
  assign intr_taken_cnt     = cnt_reg;

endmodule

// File: doc/ysyx_22040632_intr_ctrl.md
YSYX_22040632_INTR_CTRL -- requirements
Module: ysyx_22040632_intr_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the width of the PC and CSR datapath.
REQ-002 SHALL have parameter MTI_CODE, default 7, giving the machine-timer-interrupt exception code.
REQ-003 SHALL have port clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port rrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port intrrupt_timing2ex  input  1  level timer request from the CLINT.
REQ-006 SHALL have port mstatus_mie_bit  input  1  global machine interrupt enable.
REQ-007 SHALL have port mie_mtie_bit  input  1  timer interrupt enable.
REQ-008 SHALL have port ex_valid  input  1  EX holds a real, unflushed instruction.
REQ-009 SHALL have port ex_stall  input  1  EX cannot retire or be killed this cycle (memory or multicycle busy).
REQ-010 SHALL have port ex_sys_busy  input  1  EX holds ecall, ebreak, mret or a CSR write.
REQ-011 SHALL have port ex_pc  input  XLEN  PC of the EX instruction.
REQ-012 SHALL have port mtvec  input  XLEN  current mtvec value.
REQ-013 SHALL have port intrrupt_ack2clint  output  1  one-cycle take pulse returned to the CLINT.
REQ-014 SHALL have port trap_flush  output  1  kill IF, ID and EX this cycle.
REQ-015 SHALL have port redirect_valid  output  1  fetch redirect strobe.
REQ-016 SHALL have port redirect_pc  output  XLEN  handler address.
REQ-017 SHALL have port csr_trap_wen  output  1  single strobe for the CSR file: mepc<=csr_mepc_wdata, mcause<=csr_mcause_wdata, MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-018 SHALL have port csr_mepc_wdata  output  XLEN  PC to save in mepc.
REQ-019 SHALL have port csr_mcause_wdata  output  XLEN  value to write to mcause.
REQ-020 SHALL have port intr_taken_cnt  output  32  number of interrupts taken.

Function
REQ-021 SHALL define "eligible" as intrrupt_timing2ex & mstatus_mie_bit & mie_mtie_bit.
REQ-022 SHALL define "slot" as ex_valid & !ex_stall & !ex_sys_busy.
REQ-023 SHALL implement a four-state FSM: IDLE, WAIT, TAKE, DRAIN.
REQ-024 IDLE: SHALL go to TAKE next cycle if eligible & slot; else to WAIT if eligible; else stay in IDLE.
REQ-025 WAIT: SHALL go to TAKE if eligible & slot; to IDLE if !eligible (request withdrawn or enables dropped, nothing taken); else stay in WAIT.
REQ-026 TAKE: SHALL last exactly one cycle, then go to DRAIN.
REQ-027 In TAKE, SHALL assert intrrupt_ack2clint, trap_flush, redirect_valid and csr_trap_wen for exactly that cycle.
REQ-028 All four TAKE strobes SHALL be registered outputs, decoded from the state register.
REQ-029 csr_mepc_wdata SHALL be ex_pc captured in the cycle eligible & slot was sampled, then held stable through TAKE.
REQ-030 csr_mcause_wdata SHALL be {1'b1, (XLEN-1)'(MTI_CODE)}, i.e. 64'h8000_0000_0000_0007.
REQ-031 redirect_pc SHALL be {mtvec[XLEN-1:2],2'b00} when mtvec[1:0]==0 (direct mode).
REQ-032 redirect_pc SHALL be {mtvec[XLEN-1:2],2'b00}+4*MTI_CODE when mtvec[1:0]==1 (vectored mode), i.e. base+28, wrapping modulo 2^XLEN.
REQ-033 redirect_pc SHALL use the direct-mode value when mtvec[1:0] is 2 or 3.
REQ-034 redirect_pc SHALL be computed from mtvec sampled together with ex_pc.
REQ-035 DRAIN: SHALL stay until intrrupt_timing2ex==0, with a minimum of one cycle, then go to IDLE; this prevents a second take on the stale request level.
REQ-036 intr_taken_cnt SHALL increment by 1 on each TAKE cycle and saturate at 32'hFFFF_FFFF.
REQ-037 The instruction in EX at TAKE SHALL be killed, not retired; mepc points to it so it re-executes after mret.
REQ-038 If ex_valid falls during WAIT, the FSM SHALL stay in WAIT, with no take on a bubble.
REQ-039 Eligible & slot true in the same cycle as ex_sys_busy SHALL NOT take; the system instruction completes first.

Reset
REQ-040 While rrst_n==0, state SHALL be IDLE and all 1-bit outputs SHALL be 0.
REQ-041 While rrst_n==0, redirect_pc, csr_mepc_wdata and intr_taken_cnt SHALL be 0; csr_mcause_wdata is constant.
REQ-042 Reset asserted in WAIT, TAKE or DRAIN SHALL abort immediately with no strobes.
REQ-043 After reset release, the FSM SHALL re-evaluate from IDLE on the next edge.

Verification
REQ-044 Basic take: eligible in IDLE, slot=1, ex_pc=0x8000_0104, mtvec=0x8000_0000 -> next cycle one-cycle TAKE with redirect_pc=0x8000_0000, mepc_wdata=0x8000_0104, mcause=0x8000_0000_0000_0007, cnt 0->1.
REQ-045 Vectored mode: mtvec=0x8000_0001 -> redirect_pc=0x8000_001C.
REQ-046 Stall deferral: ex_stall=1 for 5 cycles with request high -> FSM stays in WAIT, no strobes; stall drops with ex_pc=0x8000_0200 -> TAKE, mepc=0x8000_0200.
REQ-047 Withdrawal: in WAIT, mstatus_mie_bit drops -> IDLE, cnt unchanged, no ack.
REQ-048 Drain: CLINT holds intrrupt_timing2ex high 3 cycles after ack -> exactly one TAKE; a new request after it drops -> second TAKE, cnt=2.
REQ-049 Reset mid-TAKE: rrst_n low in the TAKE cycle -> all strobes 0 at once, cnt=0, state IDLE.
